ctrl_mem_read: RTL and testbench

Read-side controller for the on-chip data memory. Once the memory is loaded, `start` triggers a sweep of addresses 0..MEM_SIZE-1 on a synchronous-read memory with one-cycle latency. Each word is presented to the downstream consumer over a valid/ready handshake. A two-entry output buffer absorbs backpressure without losing in-flight reads, which sustains one word per cycle when `m_ready` is held high.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/rd_skid_buf.sv | 58 +++++
 rtl/ctrl_mem_read.sv | 140 ++++++++++++++
 tb/tb_ctrl_mem_read.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory read controller.
//   rd_state_t     : sweep FSM states
//   MEM_RD_LATENCY : read latency of the data memory, in cycles
//   BUF_DEPTH      : number of entries in the output skid buffer
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_t;

    localparam int MEM_RD_LATENCY = 1;
    localparam int BUF_DEPTH      = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO that absorbs read data while the consumer stalls.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   push        : write push_data this edge
//   push_data   : word to store
//   pop         : drop the head entry this edge (may coincide with push)
//   count       : number of stored entries (0..2)
//   head        : oldest stored entry, 0 when empty
module rd_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    // One storage register per slot; the write pointer picks the slot.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] data_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                data_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_reg;
    assign head  = (count_reg == 2'd0) ? '0
                 : (rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg);

endmodule

// File: rtl/ctrl_mem_read.sv
// Read-side controller for the on-chip data memory. A start pulse sweeps
// addresses 0..MEM_SIZE-1 on a one-cycle-latency synchronous memory and
// streams each word out over a valid/ready handshake.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   start        : begin a sweep (only honoured in IDLE)
//   mem_rd_data  : memory read data, valid the cycle after mem_rd_en
//   mem_addr     : read address (registered counter)
//   mem_rd_en    : read issue strobe for mem_addr
//   m_valid      : m_data holds a word
//   m_ready      : consumer accepts the word
//   m_data       : word presented to the consumer
//   busy         : sweep in progress (STREAM or DRAIN)
//   done         : one-cycle pulse after the final handshake
module ctrl_mem_read
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 3,
    parameter int MEM_SIZE       = 8,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rd_en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      busy,
    output logic                      done
);

    localparam int ISSUE_W = (MEM_SIZE > 2) ? $clog2(MEM_SIZE) : 1;

    rd_state_t                 state_reg;
    rd_state_t                 state_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_reg;
    logic [ISSUE_W-1:0]        issue_cnt_reg;
    logic                      inflight_reg;
    logic                      done_reg;

    logic [1:0]                buf_count;
    logic [DATA_WIDTH-1:0]     buf_head;
    logic [2:0]                occupancy;
    logic                      pop;
    logic                      issue;
    logic                      last_issue;
    logic                      last_pop;
    logic                      buf_push;
    logic                      buf_pop;

    // Words owned by the controller: buffered plus the one returning from memory.
    assign occupancy = {1'b0, buf_count} + {2'b0, inflight_reg};

    // The returning word is shown directly when the buffer is empty, so the
    // first word appears the cycle it leaves the memory.
    assign m_valid = (buf_count != 2'd0) || inflight_reg;
    assign m_data  = (buf_count != 2'd0) ? buf_head
                   : (inflight_reg ? mem_rd_data : '0);
    assign pop     = m_valid && m_ready;

    // Issue only when the word will have a slot, counting a same-cycle pop.
    assign issue      = (state_reg == STREAM) &&
                        (occupancy < (3'(BUF_DEPTH) + {2'b0, pop}));
    assign last_issue = issue && (issue_cnt_reg == ISSUE_W'(MEM_SIZE - 1));
    assign last_pop   = pop && (occupancy == 3'd1);

    // A bypassed word that is consumed immediately never enters the buffer.
    assign buf_push = inflight_reg && !(pop && (buf_count == 2'd0));
    assign buf_pop  = pop && (buf_count != 2'd0);

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data (mem_rd_data),
        .pop       (buf_pop),
        .count     (buf_count),
        .head      (buf_head)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = STREAM;
            STREAM:  if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_pop)   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd_en = issue;
        busy      = (state_reg != IDLE);
    end

    // Counters, in-flight tracking and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
            inflight_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            inflight_reg <= issue;
            done_reg     <= (state_reg == DRAIN) && last_pop;
            if (issue) begin
                if (addr_reg == MEM_ADDR_WIDTH'(MEM_SIZE - 1)) begin
                    addr_reg <= '0;
                end else begin
                    addr_reg <= addr_reg + 1'b1;
                end
                if (last_issue) begin
                    issue_cnt_reg <= '0;
                end else begin
                    issue_cnt_reg <= issue_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign mem_addr = addr_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_ctrl_mem_read.sv
// Scoreboard bench for ctrl_mem_read: stimulus pushes the expected words of
// each accepted sweep; a negedge monitor pops and compares on every handshake
// and checks the done pulse follows the eighth handshake of a sweep.
module tb_ctrl_mem_read;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] mem_rd_data;
    logic [2:0] mem_addr;
    logic       mem_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       busy;
    logic       done;

    logic       start5 = 1'b0;
    logic       m_ready5 = 1'b1;
    logic [7:0] mem_rd_data5;
    logic [2:0] mem_addr5;
    logic       mem_rd_en5;
    logic       m_valid5;
    logic [7:0] m_data5;
    logic       busy5;
    logic       done5;

    logic [7:0] mem [8];
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    logic       exp_done = 1'b0;
    int         sweep_words = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         t;
    int         at;

    ctrl_mem_read #(.MEM_ADDR_WIDTH(3), .MEM_SIZE(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rd_data(mem_rd_data),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .busy(busy), .done(done)
    );

    ctrl_mem_read #(.MEM_ADDR_WIDTH(3), .MEM_SIZE(5), .DATA_WIDTH(8)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .mem_rd_data(mem_rd_data5),
        .mem_addr(mem_addr5), .mem_rd_en(mem_rd_en5), .m_valid(m_valid5),
        .m_ready(m_ready5), .m_data(m_data5), .busy(busy5), .done(done5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory models, one cycle of latency
    always @(posedge clk) if (mem_rd_en)  mem_rd_data  <= mem[mem_addr];
    always @(posedge clk) if (mem_rd_en5) mem_rd_data5 <= mem[mem_addr5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            sweep_words = 0;
            exp_done    = 1'b0;
        end else begin
            check("done", {31'b0, done}, {31'b0, exp_done});
            exp_done = 1'b0;
            check("buf_count_le2", {31'b0, (dut.buf_count <= 2'd2)}, 32'd1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL m_data: got 0x%0h, expected no word (cycle %0d)", m_data, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("m_data", {24'b0, m_data}, {24'b0, mon_exp});
                end
                $display("xfer cycle=%0d data=0x%0h", cyc, m_data);
                sweep_words++;
                if (sweep_words == 8) begin
                    exp_done    = 1'b1;
                    sweep_words = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'hA0 + 8'(i));
    endtask

    task automatic pulse_start(output int ts);
        start = 1'b1;
        tick();
        start = 1'b0;
        ts = cyc;
    endtask

    task automatic wait_done(input int bound, input bit rnd, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                at_cyc = cyc;
                break;
            end
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if (at_cyc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", bound);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},   {29'b0, mem_addr}, 32'd0);
        check({tag, "_rd_en"},  {31'b0, mem_rd_en}, 32'd0);
        check({tag, "_valid"},  {31'b0, m_valid}, 32'd0);
        check({tag, "_data"},   {24'b0, m_data}, 32'd0);
        check({tag, "_busy"},   {31'b0, busy}, 32'd0);
        check({tag, "_done"},   {31'b0, done}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        check("rst5_busy", {31'b0, busy5}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: streaming with m_ready held high
        m_ready = 1'b1;
        push_sweep();
        pulse_start(t);
        check("t1_rd_en_first", {31'b0, mem_rd_en}, 32'd1);
        check("t1_addr_first", {29'b0, mem_addr}, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t1_valid_first", {31'b0, m_valid}, 32'd1);
        check("t1_data_first", {24'b0, m_data}, 32'hA0);
        wait_done(30, 1'b0, at);
        check("t1_done_cycle", at, t + 9);
        check("t1_addr_wrapped", {29'b0, mem_addr}, 32'd0);
        tick();
        check("t1_done_one_cycle", {31'b0, done}, 32'd0);
        check("t1_idle", {31'b0, busy}, 32'd0);

        // 2: consumer stalled for 5 cycles after start
        m_ready = 1'b0;
        push_sweep();
        pulse_start(t);
        for (int i = 0; i < 5; i++) begin
            check("t2_rd_en", {31'b0, mem_rd_en}, {31'b0, (i < 2)});
            check("t2_valid", {31'b0, m_valid}, {31'b0, (i >= 1)});
            if (i >= 1) check("t2_data_hold", {24'b0, m_data}, 32'hA0);
            tick();
        end
        m_ready = 1'b1;
        wait_done(40, 1'b0, at);
        check("t2_queue_empty", exp_q.size(), 32'd0);
        tick();

        // 3: random backpressure, back-to-back sweeps
        for (int s = 0; s < 200; s++) begin
            push_sweep();
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(200, 1'b1, at);
        end
        m_ready = 1'b1;
        check("t3_queue_empty", exp_q.size(), 32'd0);
        tick();

        // 4: start ignored in STREAM and DRAIN, accepted in the done cycle
        push_sweep();
        pulse_start(t);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !(busy && !mem_rd_en); i++) tick();
        check("t4_in_drain", {31'b0, (busy && !mem_rd_en)}, 32'd1);
        m_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        m_ready = 1'b1;
        wait_done(40, 1'b0, at);
        check("t4_queue_empty", exp_q.size(), 32'd0);
        tick();
        check("t4_no_extra_sweep", {31'b0, busy}, 32'd0);
        push_sweep();
        pulse_start(t);
        wait_done(40, 1'b0, at);
        push_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_restart_rd_en", {31'b0, mem_rd_en}, 32'd1);
        check("t4_restart_addr", {29'b0, mem_addr}, 32'd0);
        wait_done(40, 1'b0, at);
        check("t4b_queue_empty", exp_q.size(), 32'd0);
        tick();

        // 5: reset in the cycle after the third handshake
        push_sweep();
        pulse_start(t);
        repeat (4) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check_reset_outputs("t5");
        tick();
        tick();
        push_sweep();
        pulse_start(t);
        tick();
        check("t5_first_after_reset", {24'b0, m_data}, 32'hA0);
        wait_done(40, 1'b0, at);
        check("t5_queue_empty", exp_q.size(), 32'd0);
        tick();

        // 6: MEM_SIZE = 5 instance
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        t = cyc;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                check("t6_rd_en", {31'b0, mem_rd_en5}, 32'd1);
                check("t6_addr", {29'b0, mem_addr5}, k);
            end else begin
                check("t6_rd_en_off", {31'b0, mem_rd_en5}, 32'd0);
            end
            if (k >= 1 && k <= 5) begin
                check("t6_valid", {31'b0, m_valid5}, 32'd1);
                check("t6_data", {24'b0, m_data5}, 32'hA0 + k - 1);
            end
            check("t6_done", {31'b0, done5}, {31'b0, (k == 6)});
            if (k == 6) check("t6_addr_wrap", {29'b0, mem_addr5}, 32'd0);
            tick();
        end
        check("t6_idle", {31'b0, busy5}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
